// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding register.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Every serial bit is held for CLKS_PER_BIT cycles of UART_clk.
module uart_tx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 UART_clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    // Reject illegal configurations at elaboration time
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be in 5..9");
        end
        if (PARITY_MODE > 2) begin : g_bad_parity_mode
            $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
            $error("uart_tx_param: CLKS_PER_BIT must be at least 1");
        end
    endgenerate

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY_MODE != 0);
    localparam logic             ODD_PARITY = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // FSM and bit-timing state
    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_n;
    logic [IDX_W-1:0]   data_idx;
    logic [IDX_W-1:0]   data_idx_n;
    logic               stop_idx;
    logic               stop_idx_n;

    // Datapath: shifter holds the frame in flight, hold is the queued word
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] shifter_n;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] hold_n;
    logic                 hold_valid;
    logic                 hold_valid_n;

    // Control strobes from the next-state logic
    logic accept;
    logic bit_last;
    logic data_last;
    logic stop_last;
    logic load_direct;
    logic load_hold;
    logic hold_load;
    logic frame_end;

    // Next values of the registered outputs
    logic tx_n;
    logic busy_n;
    logic ready_n;
    logic done_n;

    assign accept    = tx_start & tx_ready;
    assign bit_last  = (bit_cnt == CNT_LAST);
    assign data_last = (data_idx == IDX_LAST);
    assign stop_last = (stop_idx == STOP_LAST);

    // State register with bit-period and index counters
    always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            data_idx <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            data_idx <= data_idx_n;
            stop_idx <= stop_idx_n;
        end
    end

    // Next-state logic: bit sequencing and word-load decisions
    always_comb begin
        state_n     = state;
        bit_cnt_n   = '0;
        data_idx_n  = data_idx;
        stop_idx_n  = stop_idx;
        load_direct = 1'b0;
        load_hold   = 1'b0;
        hold_load   = 1'b0;
        frame_end   = 1'b0;

        if (state != IDLE && !bit_last) begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
        end

        // A word accepted while the shifter is occupied is parked in hold
        if (accept && state != IDLE) begin
            hold_load = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_n   = START;
                    load_hold = 1'b1;
                end else if (accept) begin
                    state_n     = START;
                    load_direct = 1'b1;
                end
            end
            START: begin
                if (bit_last) begin
                    state_n    = DATA;
                    data_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    if (data_last) begin
                        state_n    = HAS_PARITY ? PARITY : STOP;
                        stop_idx_n = 1'b0;
                    end else begin
                        data_idx_n = data_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_last) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                end
            end
            STOP: begin
                if (bit_last) begin
                    if (stop_last) begin
                        frame_end = 1'b1;
                        if (hold_valid) begin
                            state_n   = START;
                            load_hold = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next shifter and holding-register contents
    always_comb begin
        shifter_n    = shifter;
        hold_n       = hold;
        hold_valid_n = hold_valid;

        if (load_direct) begin
            shifter_n = data_in;
        end else if (load_hold) begin
            shifter_n    = hold;
            hold_valid_n = 1'b0;
        end

        if (hold_load) begin
            hold_n       = data_in;
            hold_valid_n = 1'b1;
        end
    end

    // Shifter and holding register storage
    always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
            shifter    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            shifter    <= shifter_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
        end
    end

    // Output decode from the upcoming state so tx changes on the same edge as the FSM
    always_comb begin
        tx_n    = 1'b1;
        busy_n  = (state_n != IDLE);
        ready_n = ~hold_valid_n;
        done_n  = frame_end;

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shifter_n[data_idx_n];
            PARITY:  tx_n = ODD_PARITY ? ~^shifter_n : ^shifter_n;
            default: tx_n = 1'b1;
        endcase
    end

    // Registered outputs; reset drives the line idle-high immediately
    always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
            tx           <= 1'b1;
            tx_ready     <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx           <= tx_n;
            tx_ready     <= ready_n;
            tx_busy      <= busy_n;
            tx_done_tick <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8O1, 7N2, 8E1) at 4 clocks per bit,
// each output compared every cycle against a frame built from the UART framing rules.
module tb_uart_tx_param;

    localparam int unsigned CPB = 4;

    localparam int NBITS [3] = '{8, 7, 8};
    localparam int PMODE [3] = '{1, 0, 2};
    localparam int NSTOP [3] = '{1, 2, 1};

    logic clk = 1'b0;
    logic rst;

    logic       st0, st1, st2;
    logic [7:0] din0;
    logic [6:0] din1;
    logic [7:0] din2;

    logic tx0, tx1, tx2;
    logic rdy0, rdy1, rdy2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;

    int vectors     = 0;
    int miscompares = 0;
    int sel         = 0;

    logic tx_m, rdy_m, busy_m, done_m;
    logic exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut_8o1 (
        .UART_clk(clk), .rst(rst), .tx_start(st0), .data_in(din0),
        .tx_ready(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_7n2 (
        .UART_clk(clk), .rst(rst), .tx_start(st1), .data_in(din1),
        .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );

    uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut_8e1 (
        .UART_clk(clk), .rst(rst), .tx_start(st2), .data_in(din2),
        .tx_ready(rdy2), .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
    );

    // Select which instance the checker is looking at
    always_comb begin
        case (sel)
            0:       begin tx_m = tx0; rdy_m = rdy0; busy_m = busy0; done_m = done0; end
            1:       begin tx_m = tx1; rdy_m = rdy1; busy_m = busy1; done_m = done1; end
            default: begin tx_m = tx2; rdy_m = rdy2; busy_m = busy2; done_m = done2; end
        endcase
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s inst=%0d time=%0t observed=%b expected=%b", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [8:0] w);
        case (sel)
            0:       begin st0 = s; din0 = w[7:0]; end
            1:       begin st1 = s; din1 = w[6:0]; end
            default: begin st2 = s; din2 = w[7:0]; end
        endcase
    endtask

    // Reference frame: start, data LSB first, parity from the ones count, stop bits
    function automatic void build_frame(input int s, input logic [8:0] w);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < NBITS[s]; i++) begin
            exp_bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (PMODE[s] == 1) exp_bits.push_back((ones % 2) == 0);
        else if (PMODE[s] == 2) exp_bits.push_back((ones % 2) == 1);
        for (int i = 0; i < NSTOP[s]; i++) exp_bits.push_back(1'b1);
    endfunction

    // Accept a word from idle; returns one cycle after the accepting edge
    task automatic idle_start(input logic [8:0] w);
        drive(1'b1, w);
        @(posedge clk); #1;
        drive(1'b0, ~w);
    endtask

    // Check one frame cycle by cycle starting at the cycle after its start edge.
    // mode 0: nothing queued; 1: queue nxt at t=2 and retry while not ready;
    // mode 2: tx_start already held high by the caller. Returns at the end-of-frame cycle.
    task automatic check_frame(input logic [8:0] w, input int mode, input logic [8:0] nxt,
                               input int abort_at);
        int   f;
        logic held;
        build_frame(sel, w);
        f    = exp_bits.size() * CPB;
        held = 1'b0;
        for (int t = 0; t < f; t++) begin
            if (t == abort_at) return;
            if (mode == 1 && t == 3) held = 1'b1;
            if (mode == 2 && t == 1) held = 1'b1;
            chk("tx_bit", tx_m, exp_bits[t / CPB]);
            chk("busy_in_frame", busy_m, 1'b1);
            chk("ready_in_frame", rdy_m, !held);
            if (t > 0) chk("done_in_frame", done_m, 1'b0);
            if (mode == 1) begin
                if (t == 2)      drive(1'b1, nxt);
                else if (t == 3) drive(1'b1, ~nxt);
                else if (t == 5) drive(1'b0, ~nxt);
            end
            @(posedge clk); #1;
        end
        chk("done_tick", done_m, 1'b1);
        chk("busy_at_end", busy_m, mode != 0);
        chk("tx_at_end", tx_m, mode == 0);
        chk("ready_at_end", rdy_m, 1'b1);
    endtask

    task automatic check_idle();
        @(posedge clk); #1;
        chk("idle_done", done_m, 1'b0);
        chk("idle_busy", busy_m, 1'b0);
        chk("idle_tx", tx_m, 1'b1);
        chk("idle_ready", rdy_m, 1'b1);
    endtask

    initial begin
        logic [8:0] w;
        logic [8:0] w2;
        int         mode;

        rst  = 1'b1;
        st0  = 1'b0; st1 = 1'b0; st2 = 1'b0;
        din0 = '0;   din1 = '0;  din2 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("reset_tx", tx_m, 1'b1);
            chk("reset_ready", rdy_m, 1'b1);
            chk("reset_busy", busy_m, 1'b0);
            chk("reset_done", done_m, 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // 8O1 single frame of 0xA5
        sel = 0;
        idle_start(9'h0A5);
        check_frame(9'h0A5, 0, 9'h0, -1);
        check_idle();

        // 8O1 back-to-back 0x00 then 0xFF, second queued mid-frame
        idle_start(9'h000);
        check_frame(9'h000, 1, 9'h0FF, -1);
        check_frame(9'h0FF, 0, 9'h0, -1);
        check_idle();

        // 7N2 frame of 0x55
        sel = 1;
        idle_start(9'h055);
        check_frame(9'h055, 0, 9'h0, -1);
        check_idle();

        // 8E1 parity cases
        sel = 2;
        idle_start(9'h007);
        check_frame(9'h007, 0, 9'h0, -1);
        check_idle();
        idle_start(9'h003);
        check_frame(9'h003, 0, 9'h0, -1);
        check_idle();

        // Reset during data bit 3, then a clean 0x3C frame
        sel = 0;
        w = 9'($urandom);
        idle_start(w);
        check_frame(w, 0, 9'h0, 4 * CPB + 1);
        rst = 1'b1;
        #1;
        chk("midreset_tx", tx_m, 1'b1);
        chk("midreset_ready", rdy_m, 1'b1);
        chk("midreset_busy", busy_m, 1'b0);
        chk("midreset_done", done_m, 1'b0);
        @(posedge clk); #1;
        chk("midreset_hold_done", done_m, 1'b0);
        rst = 1'b0;
        check_idle();
        idle_start(9'h03C);
        check_frame(9'h03C, 0, 9'h0, -1);
        check_idle();

        // tx_start held high with 0x81: one accept per ready window
        drive(1'b1, 9'h081);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check_frame(9'h081, 2, 9'h0, -1);
        end
        drive(1'b0, 9'h0);
        check_frame(9'h081, 0, 9'h0, -1);
        check_idle();

        // Randomised words on every configuration, some queued back-to-back
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int r = 0; r < 4; r++) begin
                w    = 9'($urandom);
                w2   = 9'($urandom);
                mode = int'($urandom_range(0, 1));
                idle_start(w);
                check_frame(w, mode, w2, -1);
                if (mode == 1) check_frame(w2, 0, 9'h0, -1);
                check_idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
